// File: rtl/carregador_pkg.sv
// Shared definitions for the program loader: default widths, halt word and FSM states.
// The LIMPA state exists only when CARREGADOR_LIMPA_EN is defined.
package carregador_pkg;

    localparam int         DEF_ADDR_W    = 8;
    localparam int         DEF_DATA_W    = 8;
    localparam int         DEF_MEM_DEPTH = 256;
    localparam logic [7:0] DEF_HALT_WORD = 8'h00;

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
`ifdef CARREGADOR_LIMPA_EN
        LIMPA,
`endif
        PRONTO,
        ERRO
    } estado_t;

endpackage

// File: rtl/carregador_programa_if.sv
// Host byte stream, instruction-memory write port and core-control status of the loader.
// master = host/bench side, slave = loader side.
interface carregador_programa_if
    import carregador_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              start;
    logic [DATA_W-1:0] in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] end_instr;
    logic [DATA_W-1:0] dado_instr;
    logic              escreve_instr;
    logic              reset_nucleo;
    logic              carregando;
    logic              concluido;
    logic              erro;
    logic [ADDR_W:0]   contagem;

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, end_instr, dado_instr, escreve_instr,
        input  reset_nucleo, carregando, concluido, erro, contagem
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, end_instr, dado_instr, escreve_instr,
        output reset_nucleo, carregando, concluido, erro, contagem
    );
endinterface

// File: rtl/carregador_programa_contador_endereco.sv
// Clearable incrementing instruction address counter with a terminal flag at MEM_DEPTH-1.
// The counter saturates at the terminal address so a full memory never wraps back to 0.
module contador_endereco
    import carregador_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              terminal
);
    logic [ADDR_W-1:0] count_reg;

    assign terminal = (count_reg == ADDR_W'(MEM_DEPTH - 1));
    assign count    = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !terminal) begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/carregador_programa.sv
// Program loader: writes a valid/ready byte stream into instruction memory from address 0
// and holds the core in reset until done. Optional fill of unused words: CARREGADOR_LIMPA_EN.
module carregador_programa
    import carregador_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                MEM_DEPTH = DEF_MEM_DEPTH,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    carregador_programa_if.slave bus
);
    estado_t           estado_reg;
    logic              in_ready_reg;
    logic              escreve_reg;
    logic              reset_nucleo_reg;
    logic              carregando_reg;
    logic              concluido_reg;
    logic              erro_reg;
    logic [ADDR_W-1:0] end_reg;
    logic [DATA_W-1:0] dado_reg;
    logic [ADDR_W:0]   contagem_reg;

    logic [ADDR_W-1:0] endereco;
    logic              fim;
    logic              transfer;
    logic              start_ok;
    logic              fill_step;

    // Start is honoured only outside an active load or fill.
    assign start_ok = bus.start && ((estado_reg == OCIOSO) ||
                                    (estado_reg == PRONTO) ||
                                    (estado_reg == ERRO));
    assign transfer = (estado_reg == CARREGA) && in_ready_reg && bus.in_valid;

`ifdef CARREGADOR_LIMPA_EN
    assign fill_step = (estado_reg == LIMPA);
`else
    assign fill_step = 1'b0;
`endif

    contador_endereco #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_contador (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .inc      (transfer || fill_step),
        .count    (endereco),
        .terminal (fim)
    );

    // Concluido/ResetNucleo/Erro rise one cycle after entering their state, so the
    // core is only released after the final memory write has been presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg       <= OCIOSO;
            in_ready_reg     <= 1'b0;
            escreve_reg      <= 1'b0;
            reset_nucleo_reg <= 1'b0;
            carregando_reg   <= 1'b0;
            concluido_reg    <= 1'b0;
            erro_reg         <= 1'b0;
            end_reg          <= '0;
            dado_reg         <= '0;
            contagem_reg     <= '0;
        end else begin
            escreve_reg <= 1'b0;
            if (start_ok) begin
                estado_reg       <= CARREGA;
                in_ready_reg     <= 1'b1;
                carregando_reg   <= 1'b1;
                concluido_reg    <= 1'b0;
                erro_reg         <= 1'b0;
                reset_nucleo_reg <= 1'b0;
                contagem_reg     <= '0;
            end else begin
                case (estado_reg)
                    CARREGA: begin
                        if (transfer) begin
                            end_reg      <= endereco;
                            dado_reg     <= bus.in_byte;
                            escreve_reg  <= 1'b1;
                            contagem_reg <= contagem_reg + 1'b1;
                            if (bus.in_byte == HALT_WORD) begin
                                in_ready_reg <= 1'b0;
`ifdef CARREGADOR_LIMPA_EN
                                if (!fim) begin
                                    estado_reg <= LIMPA;
                                end else begin
                                    estado_reg     <= PRONTO;
                                    carregando_reg <= 1'b0;
                                end
`else
                                estado_reg     <= PRONTO;
                                carregando_reg <= 1'b0;
`endif
                            end else if (fim) begin
                                estado_reg     <= ERRO;
                                in_ready_reg   <= 1'b0;
                                carregando_reg <= 1'b0;
                            end
                        end
                    end
`ifdef CARREGADOR_LIMPA_EN
                    LIMPA: begin
                        end_reg     <= endereco;
                        dado_reg    <= HALT_WORD;
                        escreve_reg <= 1'b1;
                        if (fim) begin
                            estado_reg     <= PRONTO;
                            carregando_reg <= 1'b0;
                        end
                    end
`endif
                    PRONTO: begin
                        concluido_reg    <= 1'b1;
                        reset_nucleo_reg <= 1'b1;
                    end
                    ERRO: begin
                        erro_reg <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.in_ready      = in_ready_reg;
    assign bus.end_instr     = end_reg;
    assign bus.dado_instr    = dado_reg;
    assign bus.escreve_instr = escreve_reg;
    assign bus.reset_nucleo  = reset_nucleo_reg;
    assign bus.carregando    = carregando_reg;
    assign bus.concluido     = concluido_reg;
    assign bus.erro          = erro_reg;
    assign bus.contagem      = contagem_reg;
endmodule

// File: tb/tb_carregador_programa.sv
// Randomized bench for carregador_programa against a memory-image reference model.
// Follows CARREGADOR_LIMPA_EN the same way the RTL does.
module tb_carregador_programa;
    import carregador_pkg::*;

    localparam int         AW    = 8;
    localparam int         DW    = 8;
    localparam int         DEPTH = 256;
    localparam logic [7:0] HALT  = 8'h00;
`ifdef CARREGADOR_LIMPA_EN
    localparam bit LIMPA_EN = 1'b1;
`else
    localparam bit LIMPA_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    carregador_programa_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    carregador_programa #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_DEPTH (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  stream_q[$];
    int          last_wr_cyc = 0;
    int          conc_cyc = 0;
    bit          conc_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed write port and the cycle in which Concluido first appears.
    always @(negedge clk) begin
        if (bus.escreve_instr) begin
            wr_q.push_back({bus.end_instr, bus.dado_instr});
            last_wr_cyc = cyc;
        end
        if (bus.concluido && !conc_seen) begin
            conc_seen = 1'b1;
            conc_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int  t;
        bit  taken;
        repeat ($urandom_range(0, gap_max)) begin
            bus.in_valid = 1'b0;
            bus.in_byte  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        t = 0;
        taken = 1'b0;
        while (!taken && t < 50) begin
            @(negedge clk);
            taken = bus.in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!taken) check("ready_timeout", 32'(taken), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input string name, input int gap_max, input int mid_start_at);
        logic [15:0] exp_q[$];
        int          h;
        int          accepted;
        bit          ok;
        bit          was_pronto;
        int          t;
        // Reference image: bytes up to the first halt at 0.., then halt fill when enabled.
        h = -1;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (stream_q[i] == HALT) begin
                h = i;
                break;
            end
        end
        ok       = (h >= 0) && (h < DEPTH);
        accepted = ok ? h + 1 : DEPTH;
        for (int i = 0; i < accepted; i++) exp_q.push_back({8'(i), stream_q[i]});
        if (ok && LIMPA_EN)
            for (int a = accepted; a < DEPTH; a++) exp_q.push_back({8'(a), HALT});

        was_pronto = bus.concluido;
        pulse_start();
        wr_q.delete();
        conc_seen = 1'b0;
        check("start_in_ready", 32'(bus.in_ready), 32'd1);
        if (was_pronto) check("start_holds_core", 32'(bus.reset_nucleo), 32'd0);

        for (int i = 0; i < accepted; i++) begin
            if (i == mid_start_at) pulse_start();
            send_byte(stream_q[i], gap_max);
        end
        repeat (3) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        t = 0;
        while (!(bus.concluido || bus.erro) && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_timeout", 32'(t < 600), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        check("wr_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check("wr_addr", 32'(wr_q[i][15:8]), 32'(exp_q[i][15:8]));
            check("wr_data", 32'(wr_q[i][7:0]), 32'(exp_q[i][7:0]));
        end
        check("contagem", 32'(bus.contagem), 32'(accepted));
        check("concluido", 32'(bus.concluido), 32'(ok));
        check("erro", 32'(bus.erro), 32'(!ok));
        check("reset_nucleo", 32'(bus.reset_nucleo), 32'(ok));
        check("carregando", 32'(bus.carregando), 32'd0);
        check("in_ready_idle", 32'(bus.in_ready), 32'd0);
        if (ok) check("concluido_latency", 32'(conc_cyc - last_wr_cyc), 32'd1);
        $display("load %s: sent=%0d writes=%0d contagem=%0d concluido=%0b erro=%0b",
                 name, accepted, wr_q.size(), bus.contagem, bus.concluido, bus.erro);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_escreve"}, 32'(bus.escreve_instr), 32'd0);
        check({tag, "_reset_nucleo"}, 32'(bus.reset_nucleo), 32'd0);
        check({tag, "_carregando"}, 32'(bus.carregando), 32'd0);
        check({tag, "_concluido"}, 32'(bus.concluido), 32'd0);
        check({tag, "_erro"}, 32'(bus.erro), 32'd0);
        check({tag, "_contagem"}, 32'(bus.contagem), 32'd0);
        check({tag, "_end_instr"}, 32'(bus.end_instr), 32'd0);
        check({tag, "_dado_instr"}, 32'(bus.dado_instr), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");

        stream_q = '{8'h41, 8'h82, 8'h00};
        load("basic", 0, -1);

        stream_q = '{8'h11, 8'h22, 8'h00};
        load("valid_gaps", 1, -1);

        for (int n = 0; n < 4; n++) begin
            int len;
            stream_q.delete();
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom_range(1, 255)));
            stream_q.push_back(HALT);
            load("random", 3, $urandom_range(1, len));
        end

        stream_q.delete();
        for (int i = 0; i < DEPTH; i++) stream_q.push_back(8'hFF);
        load("overflow", 0, -1);

        stream_q = '{8'h5A, 8'h00};
        load("after_error", 1, -1);

        stream_q.delete();
        for (int i = 0; i < DEPTH - 1; i++) stream_q.push_back(8'($urandom_range(1, 255)));
        stream_q.push_back(HALT);
        load("halt_at_last", 0, 100);

        // Abort a load after five bytes (address counter at 5).
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset asserted mid-load at address 5");

        stream_q = '{8'h33, 8'h44, 8'h55, 8'h00};
        load("after_reset", 2, -1);

        stream_q = '{8'h00};
        load("halt_only", 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
